// File: rtl/fp_to_int_iter.sv
// Iterative FP (SP/DP) to 32/64-bit integer converter: unpack, multi-cycle align,
// round, saturate. One transaction in flight; result held until out_ready.
module fp_to_int_iter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SHIFT_STEP = 8
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_fmt,
    input  logic                  in_signed_unsigned,
    input  logic                  in_output_fmt,
    input  logic [2:0]            in_rm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_invalid,
    output logic                  out_inexact
);

    localparam logic [6:0] StepAmt = 7'(SHIFT_STEP);

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StShift,
        StRound,
        StDone
    } state_e;

    state_e      state_q;
    logic [63:0] data_q;
    logic        fmt_q;
    logic        uns_q;
    logic        ofmt_q;
    logic [2:0]  rm_q;
    logic        sign_q;
    logic        nan_q;
    logic        ovf_q;
    logic        left_q;
    logic [6:0]  rem_q;
    logic [64:0] mag_q;
    logic        guard_q;
    logic        sticky_q;

    assign in_ready = (state_q == StIdle);

    // ---------------- unpack ----------------
    logic               u_sign;
    logic [10:0]        u_exp;
    logic [51:0]        u_frac;
    logic               u_exp_ones;
    logic signed [12:0] u_unb;
    logic signed [12:0] u_rdiff;
    logic               u_nan;
    logic               u_ovf;
    logic               u_zero;
    logic               u_left;
    logic [6:0]         u_rem;
    logic [64:0]        u_mag;
    logic               u_sticky;

    always_comb begin
        if (fmt_q) begin
            u_sign     = data_q[63];
            u_exp      = data_q[62:52];
            u_frac     = data_q[51:0];
            u_exp_ones = &data_q[62:52];
            u_unb      = $signed({2'b00, data_q[62:52]}) - 13'sd1023;
        end else begin
            u_sign     = data_q[31];
            u_exp      = {3'b000, data_q[30:23]};
            u_frac     = {data_q[22:0], 29'b0};
            u_exp_ones = &data_q[30:23];
            u_unb      = $signed({5'b00000, data_q[30:23]}) - 13'sd127;
        end
        u_zero   = (u_exp == 11'd0);
        u_nan    = u_exp_ones && (u_frac != 52'd0);
        u_ovf    = !u_nan && (u_exp_ones || (u_unb > 13'sd63));
        // Subnormals contribute only to sticky so directed modes still round correctly.
        u_sticky = u_zero && (u_frac != 52'd0);
        u_left   = (u_unb >= 13'sd52);
        u_rdiff  = 13'sd52 - u_unb;
        u_mag    = '0;
        u_rem    = '0;
        if (!(u_nan || u_ovf || u_zero)) begin
            u_mag = {12'b0, 1'b1, u_frac};
            if (u_left) begin
                u_rem = 7'(u_unb - 13'sd52);
            end else if (u_rdiff > 13'sd54) begin
                u_rem = 7'd54;
            end else begin
                u_rem = 7'(u_rdiff);
            end
        end
    end

    // ---------------- shift ----------------
    logic [6:0]  s_step;
    logic [65:0] s_ext;
    logic [65:0] s_low_mask;
    logic [65:0] s_rext;
    logic        s_sticky;
    logic [64:0] s_lmag;

    always_comb begin
        s_step     = (rem_q > StepAmt) ? StepAmt : rem_q;
        s_ext      = {mag_q, guard_q};
        // Bits that fall below the new guard position fold into sticky.
        s_low_mask = (66'd1 << s_step) - 66'd1;
        s_rext     = s_ext >> s_step;
        s_sticky   = sticky_q | (|(s_ext & s_low_mask));
        s_lmag     = mag_q << s_step;
    end

    // ---------------- round / saturate ----------------
    logic        r_inc;
    logic [64:0] r_mag;
    logic [64:0] r_pos_lim;
    logic [64:0] r_neg_lim;
    logic        r_oor;
    logic        r_bad;
    logic [63:0] r_sat;
    logic [63:0] r_raw;
    logic [63:0] r_final;

    always_comb begin
        case (rm_q)
            3'd1:    r_inc = 1'b0;
            3'd2:    r_inc = sign_q & (guard_q | sticky_q);
            3'd3:    r_inc = !sign_q & (guard_q | sticky_q);
            3'd4:    r_inc = guard_q;
            default: r_inc = guard_q & (sticky_q | mag_q[0]);
        endcase
        r_mag = mag_q + {64'd0, r_inc};

        if (ofmt_q) begin
            r_pos_lim = uns_q ? {1'b0, {64{1'b1}}} : {2'b0, {63{1'b1}}};
            r_neg_lim = 65'd1 << 63;
        end else begin
            r_pos_lim = uns_q ? {33'b0, {32{1'b1}}} : {34'b0, {31{1'b1}}};
            r_neg_lim = 65'd1 << 31;
        end

        if (sign_q) begin
            r_oor = uns_q ? (r_mag != 65'd0) : (r_mag > r_neg_lim);
        end else begin
            r_oor = (r_mag > r_pos_lim);
        end
        r_bad = nan_q | ovf_q | r_oor;

        if (nan_q || !sign_q) begin
            r_sat = uns_q ? {64{1'b1}} : (ofmt_q ? 64'h7FFF_FFFF_FFFF_FFFF
                                                 : 64'h0000_0000_7FFF_FFFF);
        end else begin
            r_sat = uns_q ? 64'd0 : (ofmt_q ? 64'h8000_0000_0000_0000
                                            : 64'h0000_0000_8000_0000);
        end

        r_raw   = r_bad ? r_sat : (sign_q ? (64'd0 - r_mag[63:0]) : r_mag[63:0]);
        // 32-bit results always sign-extend from bit 31, unsigned included.
        r_final = ofmt_q ? r_raw : {{32{r_raw[31]}}, r_raw[31:0]};
    end

    // ---------------- state machine ----------------
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= StIdle;
            data_q      <= '0;
            fmt_q       <= 1'b0;
            uns_q       <= 1'b0;
            ofmt_q      <= 1'b0;
            rm_q        <= '0;
            sign_q      <= 1'b0;
            nan_q       <= 1'b0;
            ovf_q       <= 1'b0;
            left_q      <= 1'b0;
            rem_q       <= '0;
            mag_q       <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        fmt_q   <= in_fmt;
                        uns_q   <= in_signed_unsigned;
                        ofmt_q  <= in_output_fmt;
                        rm_q    <= in_rm;
                        state_q <= StUnpack;
                    end
                end
                StUnpack: begin
                    sign_q   <= u_sign;
                    nan_q    <= u_nan;
                    ovf_q    <= u_ovf;
                    left_q   <= u_left;
                    rem_q    <= u_rem;
                    mag_q    <= u_mag;
                    guard_q  <= 1'b0;
                    sticky_q <= u_sticky;
                    state_q  <= (u_rem == 7'd0) ? StRound : StShift;
                end
                StShift: begin
                    if (left_q) begin
                        mag_q <= s_lmag;
                    end else begin
                        mag_q    <= s_rext[65:1];
                        guard_q  <= s_rext[0];
                        sticky_q <= s_sticky;
                    end
                    rem_q <= rem_q - s_step;
                    if (rem_q == s_step) begin
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    out_data    <= r_final;
                    out_invalid <= r_bad;
                    out_inexact <= !r_bad & (guard_q | sticky_q);
                    out_valid   <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int_iter.sv
// Directed self-checking bench for fp_to_int_iter with hand-computed expectations.
module tb_fp_to_int_iter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_fmt;
    logic        in_signed_unsigned;
    logic        in_output_fmt;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_invalid;
    logic        out_inexact;

    int total;
    int bad;
    int last_lat;

    fp_to_int_iter #(
        .DATA_WIDTH(64),
        .SHIFT_STEP(8)
    ) dut (
        .in_clk            (clk),
        .in_rst            (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_fmt            (in_fmt),
        .in_signed_unsigned(in_signed_unsigned),
        .in_output_fmt     (in_output_fmt),
        .in_rm             (in_rm),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_invalid       (out_invalid),
        .out_inexact       (out_inexact)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [63:0] d, input logic f, input logic u,
                            input logic o, input logic [2:0] rm);
        @(negedge clk);
        in_data            = d;
        in_fmt             = f;
        in_signed_unsigned = u;
        in_output_fmt      = o;
        in_rm              = rm;
        in_valid           = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [63:0] d, input logic f, input logic u,
                         input logic o, input logic [2:0] rm, input logic [63:0] exp_d,
                         input logic exp_inv, input logic exp_inx, input int hold);
        int lat;
        start_op(d, f, u, o, rm);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        last_lat = lat;
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".data"}, out_data, exp_d);
        check({tag, ".inv"}, 64'(out_invalid), 64'(exp_inv));
        check({tag, ".inx"}, 64'(out_inexact), 64'(exp_inx));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_data"}, out_data, exp_d);
            check({tag, ".hold_inv"}, 64'(out_invalid), 64'(exp_inv));
            check({tag, ".hold_inx"}, 64'(out_inexact), 64'(exp_inx));
            check({tag, ".hold_rdy"}, 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, ".done_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".done_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        total              = 0;
        bad                = 0;
        last_lat           = 0;
        rst                = 1'b1;
        in_valid           = 1'b0;
        in_data            = '0;
        in_fmt             = 1'b0;
        in_signed_unsigned = 1'b0;
        in_output_fmt      = 1'b0;
        in_rm              = 3'd0;
        out_ready          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_data", out_data, 64'd0);
        check("rst.invalid", 64'(out_invalid), 64'd0);
        check("rst.inexact", 64'(out_inexact), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // tag, data, fmt, unsigned, 64-bit, rm, expected data, invalid, inexact, hold
        do_op("dp3.5_rne", 64'h400C000000000000, 1, 0, 1, 3'd0, 64'h4, 0, 1, 0);
        check("dp3.5_lat", 64'(last_lat), 64'd9);
        do_op("dp3.5_rtz", 64'h400C000000000000, 1, 0, 1, 3'd1, 64'h3, 0, 1, 0);
        do_op("dp3.5_rm7", 64'h400C000000000000, 1, 0, 1, 3'd7, 64'h4, 0, 1, 0);
        do_op("sp-2.5_rne", 64'h00000000C0200000, 0, 0, 0, 3'd0, 64'hFFFFFFFFFFFFFFFE, 0, 1, 0);
        do_op("sp-2.5_rmm", 64'h00000000C0200000, 0, 0, 0, 3'd4, 64'hFFFFFFFFFFFFFFFD, 0, 1, 0);
        do_op("sp-2.5_u32", 64'h00000000C0200000, 0, 1, 0, 3'd0, 64'h0, 1, 0, 0);
        do_op("dp2p63_s64", 64'h43E0000000000000, 1, 0, 1, 3'd0, 64'h7FFFFFFFFFFFFFFF, 1, 0, 0);
        do_op("dp2p63_u64", 64'h43E0000000000000, 1, 1, 1, 3'd0, 64'h8000000000000000, 0, 0, 0);
        check("dp2p63_lat", 64'(last_lat), 64'd4);
        do_op("dp-2p63_s64", 64'hC3E0000000000000, 1, 0, 1, 3'd0, 64'h8000000000000000, 0, 0, 0);
        do_op("dp_carry_s32", 64'h41DFFFFFFFE00000, 1, 0, 0, 3'd0, 64'h000000007FFFFFFF, 1, 0, 0);
        do_op("sp_qnan_u32", 64'h000000007FC00000, 0, 1, 0, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0);
        do_op("dp1.0_hold", 64'h3FF0000000000000, 1, 0, 1, 3'd0, 64'h1, 0, 0, 5);
        check("dp1.0_lat", 64'(last_lat), 64'd9);
        do_op("dp2.5_rne", 64'h4004000000000000, 1, 0, 1, 3'd0, 64'h2, 0, 1, 0);
        do_op("dp-1.5_rdn", 64'hBFF8000000000000, 1, 0, 1, 3'd2, 64'hFFFFFFFFFFFFFFFE, 0, 1, 0);
        do_op("dp-1.5_rup", 64'hBFF8000000000000, 1, 0, 1, 3'd3, 64'hFFFFFFFFFFFFFFFF, 0, 1, 0);
        do_op("dp1.5_rup", 64'h3FF8000000000000, 1, 0, 1, 3'd3, 64'h2, 0, 1, 0);
        do_op("dp_zero", 64'h0000000000000000, 1, 0, 1, 3'd0, 64'h0, 0, 0, 0);
        check("dp_zero_lat", 64'(last_lat), 64'd2);
        do_op("dp-inf_s32", 64'hFFF0000000000000, 1, 0, 0, 3'd0, 64'hFFFFFFFF80000000, 1, 0, 0);
        do_op("dp_sub_rne", 64'h0000000000000001, 1, 0, 1, 3'd0, 64'h0, 0, 1, 0);
        do_op("dp_sub_rup", 64'h0000000000000001, 1, 0, 1, 3'd3, 64'h1, 0, 1, 0);
        do_op("sp2p31_u32", 64'h000000004F000000, 0, 1, 0, 3'd0, 64'hFFFFFFFF80000000, 0, 0, 0);
        do_op("sp2p31_s32", 64'h000000004F000000, 0, 0, 0, 3'd0, 64'h000000007FFFFFFF, 1, 0, 0);
        do_op("sp3.5_hi", 64'hDEADBEEF40600000, 0, 0, 0, 3'd1, 64'h3, 0, 1, 0);

        // Reset in the middle of SHIFT drops the operation.
        start_op(64'h3FF0000000000000, 1, 0, 1, 3'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.out_data", out_data, 64'd0);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            check("midrst.quiet", 64'(out_valid), 64'd0);
        end
        do_op("post_rst", 64'h400C000000000000, 1, 0, 1, 3'd0, 64'h4, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
